// File: rtl/newhope_pkg.sv
// Shared NewHope constants, codec mode encoding, codec FSM state encoding and
// a byte-order helper for the 32-bit message words.
package newhope_pkg;

   localparam int NEWHOPE_Q      = 12289;
   localparam int NEWHOPE_HALF_Q = (NEWHOPE_Q - 1) / 2;

   localparam logic MODE_ENCODE = 1'b0;
   localparam logic MODE_DECODE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ENC_WR,
      ST_DEC_RD,
      ST_DEC_ACC,
      ST_DEC_WB
   } state_t;

   // Message byte 4w+b sits in bits [31-8b -: 8] of word w. After the swap,
   // bit i of the result is message bit 32w+i, which suits LSB-first shifting.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/newhope_flipabs.sv
// Coefficient distance from HALF_Q: reduce a coefficient that lies in [0, 2Q)
// into [0, Q) with one conditional subtract, then return |x - HALF_Q|.
// Ports:
//   coef_i  in   COEF_W  raw coefficient, must be < 2Q
//   fa_o    out  COEF_W  |reduce(coef_i) - HALF_Q|
module newhope_flipabs
   import newhope_pkg::*;
#(
   parameter int COEF_W = 16,
   parameter int Q      = NEWHOPE_Q,
   parameter int HALF_Q = NEWHOPE_HALF_Q
) (
   input  logic [COEF_W-1:0] coef_i,
   output logic [COEF_W-1:0] fa_o
);

   localparam logic [COEF_W-1:0] Q_C  = COEF_W'(Q);
   localparam logic [COEF_W-1:0] HQ_C = COEF_W'(HALF_Q);

   logic [COEF_W-1:0] red;

   always_comb begin
      red  = (coef_i >= Q_C) ? coef_i - Q_C : coef_i;
      fa_o = (red >= HQ_C) ? red - HQ_C : HQ_C - red;
   end

endmodule

// File: rtl/newhope_msg_codec.sv
// NewHope message codec between the message word RAM and the polynomial RAM.
// ENCODE spreads each of the 256 message bits over COPIES = N/256 coefficients
// (0 or HALF_Q); DECODE sums |coef - HALF_Q| over the copies of each bit and
// sets the bit when the sum is below THRESH.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, mode           one-cycle request (IDLE only), 0=ENCODE 1=DECODE
//   busy, done            busy while running, one-cycle completion pulse
//   msg_addr/do/we/di     message RAM port, 32-bit words 0..7, 1-cycle read
//   poly_addr/we/di/do    polynomial RAM port, 1-cycle read
//
// state      | meaning
// IDLE       | waiting for start; done pulse is issued on return here
// LOAD       | message word address issued (ENCODE)
// ENC_WR     | one coefficient write per cycle, copies of a bit back to back
// DEC_RD     | one coefficient read per copy, accumulating returned data
// DEC_ACC    | drain of the last read, bit decision shifted in
// DEC_WB     | assembled message word written back
module newhope_msg_codec
   import newhope_pkg::*;
#(
   parameter int N      = 512,
   parameter int Q      = NEWHOPE_Q,
   parameter int COEF_W = 16,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [2:0]        msg_addr,
   input  logic [31:0]       msg_do,
   output logic              msg_we,
   output logic [31:0]       msg_di,
   output logic [AW-1:0]     poly_addr,
   output logic              poly_we,
   output logic [COEF_W-1:0] poly_di,
   input  logic [COEF_W-1:0] poly_do
);

   localparam int COPIES = N / 256;
   localparam int CW     = AW - 8;
   localparam int HALF_Q = (Q - 1) / 2;
   localparam int THRESH = (COPIES * Q) >> 2;
   localparam logic [CW-1:0] COPY_LAST = CW'(COPIES - 1);

   state_t         state_q;
   logic [7:0]     kbit_q;
   logic [CW-1:0]  copy_q;
   logic [31:0]    msg_q;
   logic [14:0]    acc_q;
   logic           done_q;

   logic [COEF_W-1:0] fa;
   logic [15:0]       sum;
   logic [31:0]       msg_sw;
   logic [31:0]       msg_cur;
   logic              first_copy;
   logic              dec_bit;

   newhope_flipabs #(.COEF_W(COEF_W), .Q(Q), .HALF_Q(HALF_Q)) u_flipabs (
      .coef_i (poly_do),
      .fa_o   (fa)
   );

   // The word read in LOAD arrives during the first write cycle of that word,
   // so that cycle takes its bit straight from the RAM and captures the word.
   assign msg_sw     = bswap32(msg_do);
   assign first_copy = (kbit_q[4:0] == 5'd0) && (copy_q == '0);
   assign msg_cur    = first_copy ? msg_sw : msg_q;
   assign sum        = {1'b0, acc_q} + 16'(fa);
   assign dec_bit    = (sum < 16'(THRESH));

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   always_comb begin
      msg_addr  = '0;
      msg_we    = 1'b0;
      msg_di    = '0;
      poly_addr = '0;
      poly_we   = 1'b0;
      poly_di   = '0;
      case (state_q)
         ST_LOAD: msg_addr = kbit_q[7:5];
         ST_ENC_WR: begin
            msg_addr  = kbit_q[7:5];
            poly_addr = {copy_q, kbit_q};
            poly_we   = 1'b1;
            poly_di   = msg_cur[0] ? COEF_W'(HALF_Q) : '0;
         end
         ST_DEC_RD: poly_addr = {copy_q, kbit_q};
         ST_DEC_WB: begin
            msg_addr = kbit_q[7:5];
            msg_we   = 1'b1;
            msg_di   = bswap32(msg_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kbit_q  <= '0;
         copy_q  <= '0;
         msg_q   <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  kbit_q  <= '0;
                  copy_q  <= '0;
                  acc_q   <= '0;
                  state_q <= (mode == MODE_DECODE) ? ST_DEC_RD : ST_LOAD;
               end
            end
            ST_LOAD: state_q <= ST_ENC_WR;
            ST_ENC_WR: begin
               if (copy_q == COPY_LAST) begin
                  msg_q  <= msg_cur >> 1;
                  copy_q <= '0;
                  kbit_q <= kbit_q + 8'd1;
                  if (kbit_q == 8'd255) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end else if (kbit_q[4:0] == 5'd31) begin
                     state_q <= ST_LOAD;
                  end
               end else begin
                  msg_q  <= msg_cur;
                  copy_q <= copy_q + CW'(1);
               end
            end
            ST_DEC_RD: begin
               // Data for copy c-1 returns while copy c is being addressed.
               if (copy_q != '0) acc_q <= sum[14:0];
               if (copy_q == COPY_LAST) begin
                  copy_q  <= '0;
                  state_q <= ST_DEC_ACC;
               end else begin
                  copy_q <= copy_q + CW'(1);
               end
            end
            ST_DEC_ACC: begin
               msg_q <= {dec_bit, msg_q[31:1]};
               acc_q <= '0;
               if (kbit_q[4:0] == 5'd31) begin
                  state_q <= ST_DEC_WB;
               end else begin
                  kbit_q  <= kbit_q + 8'd1;
                  state_q <= ST_DEC_RD;
               end
            end
            ST_DEC_WB: begin
               kbit_q <= kbit_q + 8'd1;
               if (kbit_q == 8'd255) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_DEC_RD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_newhope_msg_codec.sv
// Directed bench for newhope_msg_codec with N=512 and N=1024 instances, each
// attached to behavioural message and polynomial RAMs with 1-cycle reads.
module tb_newhope_msg_codec;
   import newhope_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s5, m5, busy5, done5, mwe5, pwe5;
   logic [2:0]  maddr5;
   logic [31:0] mdo5, mdi5;
   logic [8:0]  paddr5;
   logic [15:0] pdi5, pdo5;

   logic        s10, m10, busy10, done10, mwe10, pwe10;
   logic [2:0]  maddr10;
   logic [31:0] mdo10, mdi10;
   logic [9:0]  paddr10;
   logic [15:0] pdi10, pdo10;

   newhope_msg_codec #(.N(512), .Q(12289), .COEF_W(16), .AW(9)) u512 (
      .clk(clk), .rst(rst), .start(s5), .mode(m5), .busy(busy5), .done(done5),
      .msg_addr(maddr5), .msg_do(mdo5), .msg_we(mwe5), .msg_di(mdi5),
      .poly_addr(paddr5), .poly_we(pwe5), .poly_di(pdi5), .poly_do(pdo5));

   newhope_msg_codec #(.N(1024), .Q(12289), .COEF_W(16), .AW(10)) u1024 (
      .clk(clk), .rst(rst), .start(s10), .mode(m10), .busy(busy10), .done(done10),
      .msg_addr(maddr10), .msg_do(mdo10), .msg_we(mwe10), .msg_di(mdi10),
      .poly_addr(paddr10), .poly_we(pwe10), .poly_di(pdi10), .poly_do(pdo10));

   logic [15:0] pmem5  [512];
   logic [31:0] mmem5  [8];
   logic [15:0] pmem10 [1024];
   logic [31:0] mmem10 [8];

   logic        tb_pwe5, tb_mwe5, tb_mwe10;
   logic [9:0]  tb_addr;
   logic [31:0] tb_data;

   int pw5, mw5, dn5, pw10, ord10, bad10;

   always @(posedge clk) begin
      if (tb_pwe5) pmem5[tb_addr[8:0]] <= tb_data[15:0];
      else if (pwe5) pmem5[paddr5] <= pdi5;
      if (tb_mwe5) mmem5[tb_addr[2:0]] <= tb_data;
      else if (mwe5) mmem5[maddr5] <= mdi5;
      if (tb_mwe10) mmem10[tb_addr[2:0]] <= tb_data;
      else if (mwe10) mmem10[maddr10] <= mdi10;
      if (pwe10) pmem10[paddr10] <= pdi10;
      pdo5  <= pmem5[paddr5];
      mdo5  <= mmem5[maddr5];
      pdo10 <= pmem10[paddr10];
      mdo10 <= mmem10[maddr10];
      if (pwe5)  pw5 <= pw5 + 1;
      if (mwe5)  mw5 <= mw5 + 1;
      if (done5) dn5 <= dn5 + 1;
      if (pwe10) begin
         // expected order: copies of bit k back to back, addr = k + 256*c
         if (paddr10 !== 10'((pw10 / 4) + 256 * (pw10 % 4))) ord10 <= ord10 + 1;
         if (pdi10 !== 16'd6144) bad10 <= bad10 + 1;
         pw10 <= pw10 + 1;
      end
   end

   int n_chk, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h (%0d) expected %0h (%0d)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tbw(input int sel, input int a, input logic [31:0] d);
      tb_addr  = 10'(a);
      tb_data  = d;
      tb_pwe5  = (sel == 0);
      tb_mwe5  = (sel == 1);
      tb_mwe10 = (sel == 2);
      @(negedge clk);
      tb_pwe5  = 1'b0;
      tb_mwe5  = 1'b0;
      tb_mwe10 = 1'b0;
   endtask

   task automatic start_op(input bit big, input logic m);
      if (big) begin s10 = 1'b1; m10 = m; end
      else     begin s5  = 1'b1; m5  = m; end
      @(negedge clk);
      s5  = 1'b0;
      s10 = 1'b0;
   endtask

   task automatic wait_done(input bit big, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(big ? done10 : done5) && cyc < 3000);
   endtask

   function automatic int t4_coef(input int a);
      int k, c;
      k = a % 256;
      c = a / 256;
      case (k)
         0:       return 3072;
         1:       return (c == 0) ? 3073 : 3072;
         2:       return 18433;
         3:       return (c == 0) ? 18433 : 0;
         200:     return 6144;
         255:     return 6144;
         default: return 0;
      endcase
   endfunction

   initial begin
      int cyc, base, base2, errs, x;
      logic [31:0] exp4 [8];
      rst = 1'b1; s5 = 1'b0; m5 = 1'b0; s10 = 1'b0; m10 = 1'b0;
      tb_pwe5 = 1'b0; tb_mwe5 = 1'b0; tb_mwe10 = 1'b0; tb_addr = '0; tb_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_busy", {31'd0, busy5}, 0);
      check("rst_done", {31'd0, done5}, 0);
      check("rst_poly_we", {31'd0, pwe5}, 0);
      check("rst_msg_we", {31'd0, mwe5}, 0);
      check("rst_poly_addr", {23'd0, paddr5}, 0);
      check("rst_poly_di", {16'd0, pdi5}, 0);
      check("rst_msg_di", mdi5, 0);
      check("rst_busy_1024", {31'd0, busy10}, 0);

      // 1: N=512 encode, byte0 = 0x01
      for (int a = 0; a < 512; a++) tbw(0, a, 32'hBEEF);
      tbw(1, 0, 32'h0100_0000);
      for (int w = 1; w < 8; w++) tbw(1, w, 32'h0);
      base = pw5;
      start_op(0, MODE_ENCODE);
      check("t1_busy_after_start", {31'd0, busy5}, 1);
      wait_done(0, cyc);
      check("t1_done_cycle", cyc, 520);
      check("t1_busy_in_done", {31'd0, busy5}, 0);
      check("t1_poly_writes", pw5 - base, 512);
      @(negedge clk);
      check("t1_done_pulse_width", {31'd0, done5}, 0);
      errs = 0;
      for (int a = 0; a < 512; a++)
         if (pmem5[a] !== ((a == 0 || a == 256) ? 16'd6144 : 16'd0)) errs++;
      check("t1_poly_bad_coefs", errs, 0);
      check("t1_coef0", {16'd0, pmem5[0]}, 6144);
      check("t1_coef256", {16'd0, pmem5[256]}, 6144);

      // 2: N=1024 encode, all ones
      for (int w = 0; w < 8; w++) tbw(2, w, 32'hFFFF_FFFF);
      start_op(1, MODE_ENCODE);
      wait_done(1, cyc);
      check("t2_done_cycle", cyc, 1032);
      check("t2_poly_writes", pw10, 1024);
      check("t2_addr_order_errs", ord10, 0);
      check("t2_data_errs", bad10, 0);
      check("t2_coef1023", {16'd0, pmem10[1023]}, 6144);

      // 3: N=512 decode of the test-1 polynomial with +-1500 noise, some coefs + Q
      for (int a = 0; a < 512; a++) begin
         x = ((a == 0 || a == 256) ? 6144 : 0) + ((a * 37) % 3001) - 1500;
         if (x < 0) x += 12289;
         if (a % 3 == 0) x += 12289;
         tbw(0, a, 32'(x));
      end
      for (int w = 0; w < 8; w++) tbw(1, w, 32'hDEAD_BEEF);
      base = mw5;
      base2 = pw5;
      start_op(0, MODE_DECODE);
      wait_done(0, cyc);
      check("t3_done_cycle", cyc, 776);
      check("t3_msg_writes", mw5 - base, 8);
      check("t3_poly_writes", pw5 - base2, 0);
      check("t3_word0", mmem5[0], 32'h0100_0000);
      errs = 0;
      for (int w = 1; w < 8; w++) if (mmem5[w] !== 32'h0) errs++;
      check("t3_other_words_nonzero", errs, 0);

      // 4: threshold boundary and reduction cases
      for (int a = 0; a < 512; a++) tbw(0, a, 32'(t4_coef(a)));
      exp4 = '{32'h0600_0000, 0, 0, 0, 0, 0, 32'h0001_0000, 32'h0000_0080};
      start_op(0, MODE_DECODE);
      wait_done(0, cyc);
      check("t4_done_cycle", cyc, 776);
      for (int w = 0; w < 8; w++) check($sformatf("t4_word%0d", w), mmem5[w], exp4[w]);

      // 5: reset at cycle 100 of an encode
      for (int w = 0; w < 8; w++) tbw(1, w, 32'hFFFF_FFFF);
      start_op(0, MODE_ENCODE);
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_poly_we_after_rst", {31'd0, pwe5}, 0);
      check("t5_busy_after_rst", {31'd0, busy5}, 0);
      base = pw5;
      base2 = dn5;
      repeat (600) @(negedge clk);
      check("t5_writes_after_rst", pw5 - base, 0);
      check("t5_done_after_rst", dn5 - base2, 0);
      base = pw5;
      start_op(0, MODE_ENCODE);
      wait_done(0, cyc);
      check("t5_restart_done_cycle", cyc, 520);
      check("t5_restart_writes", pw5 - base, 512);

      // 6: start while busy ignored, start in done cycle accepted
      base = mw5;
      base2 = pw5;
      start_op(0, MODE_ENCODE);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 50) begin s5 = 1'b1; m5 = MODE_DECODE; end
         else if (cyc == 51) begin s5 = 1'b0; m5 = MODE_ENCODE; end
      end while (!done5 && cyc < 3000);
      check("t6_done_cycle_busy_start", cyc, 520);
      check("t6_no_msg_writes", mw5 - base, 0);
      check("t6_poly_writes", pw5 - base2, 512);
      start_op(0, MODE_ENCODE);
      check("t6_busy_after_done_start", {31'd0, busy5}, 1);
      check("t6_done_low_after_start", {31'd0, done5}, 0);
      wait_done(0, cyc);
      check("t6_second_run_done_cycle", cyc, 520);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
